ll_update_seq: RTL
==================

# ll_update_seq

Per-tick physics sequencer for the lander state. On each game tick it runs four operations, one per cycle, through a single shared `bcdaddsub4` adder, and updates altitude, velocity and fuel in 4-digit BCD. It sits between the tick generator and `ll_control`:

- its `alt`/`vel` outputs feed the landing/crash detector;
- the detector's `wen` freezes it.

## Interface
Parameters:
- `ALT_INIT`, 16'h4500, altitude after reset (BCD).
- `VEL_INIT`, 16'h0000, velocity after reset (BCD, 10's complement).
- `FUEL_INIT`, 16'h0800, fuel after reset (BCD).
- `GRAVITY`, 16'h0005, per-tick gravity, subtracted from velocity.

Ports:
- `clk` in 1: system clock; all state updates on the posedge.
- `rst` in 1: asynchronous, active-low reset.
- `tick` in 1: one-cycle pulse that requests one physics update.
- `wen` in 1: write-enable from `ll_control`; 0 means the state is frozen.
- `thrust` in 16: requested thrust (BCD, 0000–0009).
- `alt` out 16: current altitude (BCD, 10's complement).
- `vel` out 16: current velocity (BCD, 10's complement).
- `fuel` out 16: current fuel (BCD, non-negative).
- `busy` out 1: high while a sequence is in progress.
- `upd_valid` out 1: one-cycle pulse; `alt`/`vel`/`fuel` hold the new values.

## Operation
- Exactly one `bcdaddsub4` instance (`op` 0 = a+b, 1 = a−b). Its operands and `op` are muxed by state.
- Intermediate results go to a 16-bit scratch register `acc`.
- Working copies `alt_w`, `vel_w`, `fuel_w` and `thr_eff` are captured at start. Architectural outputs change only at commit.
- States:
  - **IDLE**: if `tick` && `wen`, capture `alt`/`vel`/`fuel` into the working copies, compute and latch `thr_eff`, go to ALT. Otherwise stay.
  - **ALT**: `alt_w` ← `alt_w` + `vel_w`. Go to VT.
  - **VT**: `acc` ← `vel_w` + `thr_eff`. Go to VG.
  - **VG**: `vel_w` ← `acc` − `GRAVITY`. Go to FUEL.
  - **FUEL**: compute `fuel_w` − `thr_eff`. At this edge, commit `alt` ← `alt_w`, `vel` ← `vel_w`, `fuel` ← that result. Go to DONE.
  - **DONE**: `upd_valid` = 1. Go to IDLE.
- `busy` = (state != IDLE).
- `thr_eff` = `thrust`, subject to the fuel clamp under Configuration.
- All arithmetic is 4-digit BCD, 10's complement. Negative values have MS nibble 9. No overflow detection; results wrap mod 10000.
- Altitude is not clamped at 0. `ll_control` detects ground contact from `alt`+`vel`.
- `tick` in any state other than IDLE is ignored. It is not queued.
- `tick` with `wen` = 0 is ignored: no state change, no `upd_valid`.
- `wen` falling mid-sequence does not abort. The in-flight sequence commits, because `wen` is qualified only at start.
- `rst` asserted in any state:
  - state → IDLE;
  - `alt`/`vel`/`fuel` → `ALT_INIT`/`VEL_INIT`/`FUEL_INIT`;
  - `busy` = 0, `upd_valid` = 0;
  - working registers and `acc` → 0.

## Timing
- `tick` sampled high at edge E0 in IDLE. States: ALT after E0, VT after E1, VG after E2, FUEL after E3. Commit at E4. DONE is the cycle after E4. IDLE after E5.
- `busy` is high from E0 through E5 (5 cycles).
- `upd_valid` is high for exactly one cycle after E4. Outputs show the new values in that same cycle.
- Minimum tick spacing for every tick to be serviced: 6 cycles.
- Outputs are registered. `busy` and `upd_valid` are decoded from the state register.

## Configuration
- `LL_UPDATE_FUEL_CLAMP_EN` defined:
  - at capture, `thr_eff` = `thrust` if `fuel` ≥ `thrust` (unsigned BCD compare), else `fuel`;
  - fuel never goes below 0000.
- Not defined:
  - `thr_eff` = `thrust` always;
  - fuel may wrap into 10's-complement negative; e.g. 0003 − 0009 = 9994.

## Test plan
- Reset, then `tick` with `thrust` = 0004, `wen` = 1 → `upd_valid` one cycle after E4; `alt` = 4500, `vel` = 9999, `fuel` = 0796, `busy` high 5 cycles.
- Second `tick`, same `thrust` → `alt` = 4499, `vel` = 9998, `fuel` = 0792.
- `fuel` = 0003, `thrust` = 0009, `vel` = 0000, `tick`:
  - macro defined → `vel` = 9998, `fuel` = 0000;
  - macro undefined → `vel` = 0004, `fuel` = 9994.
- `tick` pulses at E0 and E2 → only one sequence runs, one `upd_valid`, values reflect a single update.
- `wen` = 0, `tick` → `busy` stays 0, no `upd_valid`, outputs unchanged. `wen` dropped at E2 of a running sequence → commit still occurs at E4.
- `rst` low during VG → immediately `busy` = 0, `alt` = 4500, `vel` = 0000, `fuel` = 0800. A `tick` after release runs a full sequence normally.

Source files
------------

// File: rtl/ll_update_seq.sv
// Per-tick lander physics sequencer: alt/vel/fuel updated in 4-digit BCD through one shared adder.
// Optional feature: define LL_UPDATE_FUEL_CLAMP_EN to limit effective thrust to the remaining fuel.

module bcdaddsub4 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        op_i,
    output logic [15:0] y_o
);

    // One BCD digit add with carry; returns {carry_out, digit}.
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] x, input logic [3:0] y, input logic cin);
        logic [4:0] sum;
        sum = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
        if (sum > 5'd9) begin
            bcd_digit_add = {1'b1, 4'(sum - 5'd10)};
        end else begin
            bcd_digit_add = {1'b0, sum[3:0]};
        end
    endfunction

    logic [4:0] dig_s;
    logic [3:0] b_dig_s;
    logic       carry_s;

    // Subtraction is a + 9's complement of b with carry-in 1; the final carry is discarded (mod 10000).
    always_comb begin
        y_o     = 16'h0000;
        carry_s = op_i;
        dig_s   = 5'd0;
        b_dig_s = 4'd0;
        for (int i = 0; i < 4; i++) begin
            if (op_i) begin
                b_dig_s = 4'd9 - b_i[4*i +: 4];
            end else begin
                b_dig_s = b_i[4*i +: 4];
            end
            dig_s          = bcd_digit_add(a_i[4*i +: 4], b_dig_s, carry_s);
            y_o[4*i +: 4]  = dig_s[3:0];
            carry_s        = dig_s[4];
        end
    end

endmodule

module ll_update_seq #(
    parameter logic [15:0] ALT_INIT  = 16'h4500,
    parameter logic [15:0] VEL_INIT  = 16'h0000,
    parameter logic [15:0] FUEL_INIT = 16'h0800,
    parameter logic [15:0] GRAVITY   = 16'h0005
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        wen,
    input  logic [15:0] thrust,
    output logic [15:0] alt,
    output logic [15:0] vel,
    output logic [15:0] fuel,
    output logic        busy,
    output logic        upd_valid
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ALT  = 3'd1,
        S_VT   = 3'd2,
        S_VG   = 3'd3,
        S_FUEL = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] alt_q, alt_d, vel_q, vel_d, fuel_q, fuel_d;
    logic [15:0] alt_w_q, alt_w_d, vel_w_q, vel_w_d, fuel_w_q, fuel_w_d;
    logic [15:0] thr_eff_q, thr_eff_d, acc_q, acc_d;
    logic [15:0] add_a_s, add_b_s, add_y_s, thr_sel_s;
    logic        add_op_s;

    bcdaddsub4 u_adder (
        .a_i  (add_a_s),
        .b_i  (add_b_s),
        .op_i (add_op_s),
        .y_o  (add_y_s)
    );

    // Effective thrust chosen at capture time.
    always_comb begin
`ifdef LL_UPDATE_FUEL_CLAMP_EN
        if (fuel_q >= thrust) begin
            thr_sel_s = thrust;
        end else begin
            thr_sel_s = fuel_q;
        end
`else
        thr_sel_s = thrust;
`endif
    end

    // Adder operand mux and next-state / datapath updates.
    always_comb begin
        add_a_s   = 16'h0000;
        add_b_s   = 16'h0000;
        add_op_s  = 1'b0;
        state_d   = state_q;
        alt_d     = alt_q;
        vel_d     = vel_q;
        fuel_d    = fuel_q;
        alt_w_d   = alt_w_q;
        vel_w_d   = vel_w_q;
        fuel_w_d  = fuel_w_q;
        thr_eff_d = thr_eff_q;
        acc_d     = acc_q;
        case (state_q)
            S_IDLE: begin
                if (tick && wen) begin
                    alt_w_d   = alt_q;
                    vel_w_d   = vel_q;
                    fuel_w_d  = fuel_q;
                    thr_eff_d = thr_sel_s;
                    state_d   = S_ALT;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_ALT: begin
                add_a_s = alt_w_q;
                add_b_s = vel_w_q;
                alt_w_d = add_y_s;
                state_d = S_VT;
            end
            S_VT: begin
                add_a_s = vel_w_q;
                add_b_s = thr_eff_q;
                acc_d   = add_y_s;
                state_d = S_VG;
            end
            S_VG: begin
                add_a_s  = acc_q;
                add_b_s  = GRAVITY;
                add_op_s = 1'b1;
                vel_w_d  = add_y_s;
                state_d  = S_FUEL;
            end
            S_FUEL: begin
                add_a_s  = fuel_w_q;
                add_b_s  = thr_eff_q;
                add_op_s = 1'b1;
                fuel_w_d = add_y_s;
                alt_d    = alt_w_q;
                vel_d    = vel_w_q;
                fuel_d   = add_y_s;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            alt_q     <= ALT_INIT;
            vel_q     <= VEL_INIT;
            fuel_q    <= FUEL_INIT;
            alt_w_q   <= 16'h0000;
            vel_w_q   <= 16'h0000;
            fuel_w_q  <= 16'h0000;
            thr_eff_q <= 16'h0000;
            acc_q     <= 16'h0000;
        end else begin
            state_q   <= state_d;
            alt_q     <= alt_d;
            vel_q     <= vel_d;
            fuel_q    <= fuel_d;
            alt_w_q   <= alt_w_d;
            vel_w_q   <= vel_w_d;
            fuel_w_q  <= fuel_w_d;
            thr_eff_q <= thr_eff_d;
            acc_q     <= acc_d;
        end
    end

    assign alt       = alt_q;
    assign vel       = vel_q;
    assign fuel      = fuel_q;
    assign busy      = (state_q != S_IDLE);
    assign upd_valid = (state_q == S_DONE);

endmodule
